// File: rtl/instr_mem_sync.sv
// Loadable synchronous instruction memory with a post-reset NOP clear sweep.
// Optional feature macro: INSTR_MEM_PARITY_EN (per-word even parity and inject_flip task).
module instr_mem_sync #(
  parameter int                     DEPTH       = 256,
  parameter int                     INSTR_WIDTH = 9,
  parameter int                     ADDR_WIDTH  = $clog2(DEPTH) + 1,
  parameter logic [INSTR_WIDTH-1:0] NOP_WORD    = 'b001000110
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   ready,
  input  logic                   load_en,
  input  logic [ADDR_WIDTH-1:0]  load_addr,
  input  logic [INSTR_WIDTH-1:0] load_data,
  output logic                   load_err,
  input  logic                   fetch_req,
  input  logic [ADDR_WIDTH-1:0]  fetch_addr,
  input  logic                   fetch_stall,
  output logic [INSTR_WIDTH-1:0] instr_out,
  output logic                   instr_valid,
  output logic                   addr_fault,
  output logic                   parity_err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef INSTR_MEM_PARITY_EN
  localparam int MW = INSTR_WIDTH + 1;
`else
  localparam int MW = INSTR_WIDTH;
`endif
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A  = ADDR_WIDTH'(DEPTH);
  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic {S_CLEAR, S_RUN} state_e;

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       cnt_q, cnt_d;
  logic [MW-1:0]          mem [DEPTH];
  logic                   mem_we;
  logic [IDX_W-1:0]       mem_waddr;
  logic [MW-1:0]          mem_wdata;

  logic [INSTR_WIDTH-1:0] instr_q;
  logic                   valid_q;
  logic                   fault_q;
  logic                   load_err_q;

  logic                   run;
  logic                   load_in_range;
  logic                   load_ok;
  logic                   load_rej;
  logic                   fetch_in_range;
  logic [IDX_W-1:0]       fetch_idx;

  // Stored word carries its even-parity bit in the MSB when parity is enabled.
  function automatic logic [MW-1:0] encode(input logic [INSTR_WIDTH-1:0] data);
`ifdef INSTR_MEM_PARITY_EN
    return {^data, data};
`else
    return data;
`endif
  endfunction

  assign run            = (state_q == S_RUN);
  assign load_in_range  = (load_addr < DEPTH_A);
  assign load_ok        = run && load_en && load_in_range;
  assign load_rej       = load_en && (!run || !load_in_range);
  assign fetch_in_range = (fetch_addr < DEPTH_A);
  assign fetch_idx      = fetch_addr[IDX_W-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_we    = 1'b0;
    mem_waddr = cnt_q;
    mem_wdata = encode(NOP_WORD);
    case (state_q)
      S_CLEAR: begin
        mem_we = 1'b1;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST_IDX) state_d = S_RUN;
      end
      S_RUN: begin
        if (load_ok) begin
          mem_we    = 1'b1;
          mem_waddr = load_addr[IDX_W-1:0];
          mem_wdata = encode(load_data);
        end
      end
      default: state_d = S_CLEAR;
    endcase
  end

  // Write port; reset suppresses any write in the same cycle.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) mem[mem_waddr] <= mem_wdata;
  end

`ifdef INSTR_MEM_PARITY_EN
  logic perr_q;

  task automatic inject_flip(input int unsigned addr, input int unsigned bit_idx);
    mem[addr][bit_idx] <= ~mem[addr][bit_idx];
  endtask
`endif

  // Read port; the old word is read even when a load hits the same address.
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q    <= '0;
      valid_q    <= 1'b0;
      fault_q    <= 1'b0;
      load_err_q <= 1'b0;
`ifdef INSTR_MEM_PARITY_EN
      perr_q     <= 1'b0;
`endif
    end else begin
      load_err_q <= load_rej;
      if (run) begin
        if (!fetch_stall) begin
          if (fetch_req) begin
            valid_q <= 1'b1;
            if (fetch_in_range) begin
              instr_q <= mem[fetch_idx][INSTR_WIDTH-1:0];
              fault_q <= 1'b0;
`ifdef INSTR_MEM_PARITY_EN
              perr_q  <= ^mem[fetch_idx];
`endif
            end else begin
              instr_q <= NOP_WORD;
              fault_q <= 1'b1;
`ifdef INSTR_MEM_PARITY_EN
              perr_q  <= 1'b0;
`endif
            end
          end else begin
            valid_q <= 1'b0;
            fault_q <= 1'b0;
`ifdef INSTR_MEM_PARITY_EN
            perr_q  <= 1'b0;
`endif
          end
        end
      end else begin
        valid_q <= 1'b0;
      end
    end
  end

  assign ready       = run;
  assign instr_out   = instr_q;
  assign instr_valid = valid_q;
  assign addr_fault  = fault_q;
  assign load_err    = load_err_q;
`ifdef INSTR_MEM_PARITY_EN
  assign parity_err  = perr_q;
`else
  assign parity_err  = 1'b0;
`endif

endmodule

// File: doc/instr_mem_sync.md
# instr_mem_sync

Synchronous, loadable instruction memory: a parametrised successor to the combinational test ROM that feeds the fetch stage. It stores `DEPTH` words of `INSTR_WIDTH` bits and returns a registered instruction one cycle after a fetch request. Backend stalls freeze the output. After every reset, a hardware sweep fills the whole array with a NOP word. A write port lets testbenches or a boot loader place programs into memory, so no program is hard-coded in RTL.

## Interface
Parameters:
- `DEPTH`, 256, number of instruction words; any value ≥ 2, not necessarily a power of two.
- `INSTR_WIDTH`, 9, instruction word width in bits.
- `ADDR_WIDTH`, `$clog2(DEPTH)+1`, address width; the extra MSB allows out-of-range detection.
- `NOP_WORD`, `'b001000110`, value written by the clear sweep and returned on faults.

Ports:
- `clk`  in  1  single clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `ready`  out  1  memory initialised and accepting fetches and loads.
- `load_en`  in  1  write strobe.
- `load_addr`  in  `ADDR_WIDTH`  write address.
- `load_data`  in  `INSTR_WIDTH`  write data.
- `load_err`  out  1  pulse: the write was rejected (busy or out of range).
- `fetch_req`  in  1  fetch request.
- `fetch_addr`  in  `ADDR_WIDTH`  fetch address.
- `fetch_stall`  in  1  hold the current output; ignore `fetch_req`.
- `instr_out`  out  `INSTR_WIDTH`  registered instruction.
- `instr_valid`  out  1  `instr_out` holds the result of a fetch accepted in the previous cycle.
- `addr_fault`  out  1  the accepted fetch address was ≥ `DEPTH`.
- `parity_err`  out  1  see Configuration.

Decided: one clock; reset is synchronous and active-high; ports are named `clk` and `reset`.

## Operation
- The FSM has two states: CLEAR and RUN.
- Reset action: state←CLEAR, sweep counter←0.
- Reset values: `ready`=0, `instr_out`=0, `instr_valid`=0, `addr_fault`=0, `load_err`=0, `parity_err`=0.
- CLEAR: each cycle, mem[cnt]←`NOP_WORD` and cnt increments. When cnt=`DEPTH-1` is written, the next state is RUN.
- RUN: `ready`=1. Reset is the only way out of RUN.
- Load, accepted when RUN, `load_en`=1 and `load_addr`<`DEPTH`: mem[load_addr]←load_data.
- Load rejected: if `load_en`=1 in CLEAR, or `load_addr`≥`DEPTH`, then `load_err`=1 for one cycle and memory is unchanged.
- Fetch is accepted when RUN, `fetch_req`=1 and `fetch_stall`=0. On the next edge:
  - `instr_valid`=1.
  - `instr_out`=mem[fetch_addr], or `NOP_WORD` with `addr_fault`=1 if `fetch_addr`≥`DEPTH`.
- RUN, `fetch_stall`=0, `fetch_req`=0: `instr_valid`←0, `addr_fault`←0, `instr_out` holds.
- `fetch_stall`=1: `instr_out`, `instr_valid` and `addr_fault` all hold; the request is dropped, and the requester must re-present it.
- Fetch during CLEAR: ignored; `instr_valid`=0.
- Load and fetch on the same address in the same cycle: read-before-write, so the old word is returned and the new word is stored.

## Timing
- Fetch latency is 1 cycle from the accepting edge to `instr_valid`/`instr_out`.
- Throughput is one fetch per cycle.
- `ready` rises `DEPTH` cycles after the first edge at which `reset` is low. With `DEPTH`=256, that is edge 256.
- `load_err` is registered and asserts the cycle after the offending strobe.
- Reset during CLEAR restarts the sweep at address 0.
- Reset during RUN re-clears all memory, so loaded programs are lost.
- Reset has priority over load, fetch and stall in the same cycle.

## Configuration
- `INSTR_MEM_PARITY_EN` defined:
  - Each word stores one extra even-parity bit, computed on both load and clear.
  - On an accepted fetch, a mismatch sets `parity_err`=1 alongside `instr_valid`.
  - `parity_err` follows the same hold and clear rules as `addr_fault`.
  - The bench can flip a stored bit with the hierarchical task `inject_flip(addr, bit)`.
- Not defined: there is no parity storage, and `parity_err` is tied to 0.

## Test plan
- Reset release, `DEPTH`=256: `ready`=0 for edges 1–255 and 1 at edge 256. Then fetching addr 0, 128 and 255 each returns `'b001000110` with `instr_valid`=1 one cycle later.
- Load addr 7←`'b111010110`, then fetch 7: `instr_out`=`'b111010110`. Back-to-back fetches 7, 8, 7 return valid words on three consecutive cycles.
- Fetch addr 256: `instr_out`=`NOP_WORD`, `addr_fault`=1 for one cycle. Load addr 300: `load_err`=1 and memory is unchanged.
- After fetching 7, assert `fetch_stall` for 3 cycles while presenting fetch 8: output holds `'b111010110` with `instr_valid`=1. Releasing the stall with fetch 8 re-presented returns word 8 one cycle later.
- Reset mid-sweep at cycle 100 and again in RUN after loading addr 9: the sweep restarts, `ready` returns 256 cycles later, and addr 9 reads `NOP_WORD`.
- With `INSTR_MEM_PARITY_EN`: load addr 3←`'b101001000`, flip bit 2, fetch 3 → `parity_err`=1. Without the macro, the same sequence gives `parity_err`=0.
